ber_align_ctrl: RTL and testbench

Receive-side alignment controller for the PRBS9 + BPSK + RC + BER link. After RX enable, it sweeps the receiver sampling offset (phase 0..OS-1) and the reference-PRBS delay (0..DELAY_MAX-1). For each pair it measures errors over a fixed window, then selects and locks the pair with the fewest errors. In lock it runs the continuous 64-bit bit/error counters that drive the BER = 0 indicator. It sits between the baud strobe from `control`, the RX sample mux (`o_offset`) and the reference delay line (`o_delay`).

---
 rtl/ber_align_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ber_align_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ber_align_ctrl.sv
// Receive alignment controller: sweeps sampling offset x reference delay, locks the
// pair with the fewest window errors, then runs saturating BER counters.
// Optional feature macro BER_ALIGN_EARLY_LOCK_EN: lock on the first zero-error window.
module ber_align_ctrl #(
  parameter  int OS           = 4,
  parameter  int DELAY_MAX    = 511,
  parameter  int NB_WINDOW    = 10,
  parameter  int SETTLE_BAUDS = 4,
  parameter  int NB_COUNT     = 64,
  localparam int NB_OFF       = (OS > 1) ? $clog2(OS) : 1
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic                i_error,
  output logic [NB_OFF-1:0]   o_offset,
  output logic [8:0]          o_delay,
  output logic                o_locked,
  output logic [NB_WINDOW:0]  o_best_err,
  output logic [NB_COUNT-1:0] o_bit_count,
  output logic [NB_COUNT-1:0] o_error_count
);

  localparam int NB_SET = (SETTLE_BAUDS > 1) ? $clog2(SETTLE_BAUDS) : 1;
  localparam logic [NB_SET-1:0] SET_LAST = NB_SET'(SETTLE_BAUDS - 1);
  localparam logic [NB_OFF-1:0] OFF_LAST = NB_OFF'(OS - 1);
  localparam logic [8:0]        DLY_LAST = 9'(DELAY_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SETTLE      = 3'd1,
    S_MEASURE     = 3'd2,
    S_NEXT        = 3'd3,
    S_LOCK_SETTLE = 3'd4,
    S_LOCK        = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [NB_OFF-1:0]     offset_q, offset_d, best_off_q, best_off_d;
  logic [8:0]            delay_q, delay_d, best_dly_q, best_dly_d;
  logic [NB_WINDOW:0]    best_err_q, best_err_d, win_err_q, win_err_d;
  logic [NB_WINDOW-1:0]  win_cnt_q, win_cnt_d;
  logic [NB_SET-1:0]     set_cnt_q, set_cnt_d;
  logic                  locked_q, locked_d;
  logic [NB_COUNT-1:0]   bit_cnt_q, bit_cnt_d, err_cnt_q, err_cnt_d;
  logic                  last_pair_s, zero_hit_s;

  // Next-state and datapath updates; a low enable overrides everything and freezes the datapath.
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    delay_d     = delay_q;
    best_off_d  = best_off_q;
    best_dly_d  = best_dly_q;
    best_err_d  = best_err_q;
    win_err_d   = win_err_q;
    win_cnt_d   = win_cnt_q;
    set_cnt_d   = set_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    last_pair_s = (offset_q == OFF_LAST) && (delay_q == DLY_LAST);
`ifdef BER_ALIGN_EARLY_LOCK_EN
    zero_hit_s  = (win_err_q == '0);
`else
    zero_hit_s  = 1'b0;
`endif
    if (!i_enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d    = S_SETTLE;
          offset_d   = '0;
          delay_d    = '0;
          best_err_d = '1;
          bit_cnt_d  = '0;
          err_cnt_d  = '0;
          set_cnt_d  = '0;
        end
        S_SETTLE, S_LOCK_SETTLE: begin
          if (i_valid) begin
            if (set_cnt_q == SET_LAST) begin
              state_d   = (state_q == S_SETTLE) ? S_MEASURE : S_LOCK;
              set_cnt_d = '0;
              win_cnt_d = '0;
              win_err_d = '0;
            end else begin
              set_cnt_d = set_cnt_q + NB_SET'(1'b1);
            end
          end else begin
            set_cnt_d = set_cnt_q;
          end
        end
        S_MEASURE: begin
          if (i_valid) begin
            win_cnt_d = win_cnt_q + NB_WINDOW'(1'b1);
            win_err_d = win_err_q + (NB_WINDOW + 1)'(i_error);
            if (win_cnt_q == '1) begin
              state_d = S_NEXT;
            end else begin
              state_d = S_MEASURE;
            end
          end else begin
            win_cnt_d = win_cnt_q;
          end
        end
        S_NEXT: begin
          // Strict compare keeps the earliest pair on ties.
          if (win_err_q < best_err_q) begin
            best_err_d = win_err_q;
            best_off_d = offset_q;
            best_dly_d = delay_q;
          end else begin
            best_err_d = best_err_q;
          end
          set_cnt_d = '0;
          if (last_pair_s || zero_hit_s) begin
            state_d  = S_LOCK_SETTLE;
            offset_d = best_off_d;
            delay_d  = best_dly_d;
          end else begin
            state_d = S_SETTLE;
            if (delay_q == DLY_LAST) begin
              delay_d  = '0;
              offset_d = offset_q + NB_OFF'(1'b1);
            end else begin
              delay_d = delay_q + 9'd1;
            end
          end
        end
        S_LOCK: begin
          if (i_valid) begin
            if (bit_cnt_q != '1) begin
              bit_cnt_d = bit_cnt_q + NB_COUNT'(1'b1);
            end else begin
              bit_cnt_d = bit_cnt_q;
            end
            if (i_error && (err_cnt_q != '1)) begin
              err_cnt_d = err_cnt_q + NB_COUNT'(1'b1);
            end else begin
              err_cnt_d = err_cnt_q;
            end
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    locked_d = (state_d == S_LOCK);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      offset_q   <= '0;
      delay_q    <= '0;
      best_off_q <= '0;
      best_dly_q <= '0;
      best_err_q <= '1;
      win_err_q  <= '0;
      win_cnt_q  <= '0;
      set_cnt_q  <= '0;
      locked_q   <= 1'b0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      delay_q    <= delay_d;
      best_off_q <= best_off_d;
      best_dly_q <= best_dly_d;
      best_err_q <= best_err_d;
      win_err_q  <= win_err_d;
      win_cnt_q  <= win_cnt_d;
      set_cnt_q  <= set_cnt_d;
      locked_q   <= locked_d;
      bit_cnt_q  <= bit_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_offset      = offset_q;
  assign o_delay       = delay_q;
  assign o_locked      = locked_q;
  assign o_best_err    = best_err_q;
  assign o_bit_count   = bit_cnt_q;
  assign o_error_count = err_cnt_q;

endmodule

// File: tb/tb_ber_align_ctrl.sv
// Randomized bench for ber_align_ctrl: per-window error budgets drive the link,
// an argmin model predicts the locked pair, counters are checked against tallies.
module tb_ber_align_ctrl;
  localparam int OS = 4, DMAX = 5, NBW = 3, SET = 2;
  localparam int NWIN = OS * DMAX, WLEN = 1 << NBW;

  logic clock = 1'b0;
  logic i_reset, i_enable, i_valid, i_error;
  logic [1:0]  o_offset,  s_offset;
  logic [8:0]  o_delay,   s_delay;
  logic        o_locked,  s_locked;
  logic [3:0]  o_best_err, s_best_err;
  logic [63:0] o_bit_count, o_error_count;
  logic [3:0]  s_bit_count, s_error_count;

  ber_align_ctrl #(.OS(OS), .DELAY_MAX(DMAX), .NB_WINDOW(NBW), .SETTLE_BAUDS(SET), .NB_COUNT(64)) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid), .i_error(i_error),
    .o_offset(o_offset), .o_delay(o_delay), .o_locked(o_locked), .o_best_err(o_best_err),
    .o_bit_count(o_bit_count), .o_error_count(o_error_count));

  ber_align_ctrl #(.OS(OS), .DELAY_MAX(DMAX), .NB_WINDOW(NBW), .SETTLE_BAUDS(SET), .NB_COUNT(4)) dut_sat (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid), .i_error(i_error),
    .o_offset(s_offset), .o_delay(s_delay), .o_locked(s_locked), .o_best_err(s_best_err),
    .o_bit_count(s_bit_count), .o_error_count(s_error_count));

  always #5 clock = ~clock;

  int n_vec = 0, n_fail = 0;
  int win_errs[NWIN];
  int obs_off[NWIN];
  int obs_dly[NWIN];
  int lock_off, lock_dly;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One baud: strobe for a clock, then three idle clocks with junk on i_error.
  task automatic strobe(input logic e);
    i_valid = 1'b1;
    i_error = e;
    tick();
    i_valid = 1'b0;
    repeat (3) begin
      i_error = 1'($urandom);
      tick();
    end
  endtask

  // Drives nwin windows, recording the pair the DUT presents at each window start.
  task automatic drive_windows(input int nwin);
    int r;
    logic e;
    for (int w = 0; w < nwin; w++) begin
      obs_off[w] = o_offset;
      obs_dly[w] = o_delay;
      repeat (SET) strobe(1'($urandom));
      r = win_errs[w];
      for (int s = WLEN; s > 0; s--) begin
        e = ($urandom_range(s - 1, 0) < r);
        if (e) r--;
        strobe(e);
      end
    end
  endtask

  // Reference: argmin over window error counts, first minimum wins.
  function automatic void predict(output int eoff, output int edly, output int eerr, output int nwin);
    int bw;
    eerr = 1 << 30;
    bw = 0;
    nwin = NWIN;
    for (int w = 0; w < NWIN; w++) begin
      if (win_errs[w] < eerr) begin
        eerr = win_errs[w];
        bw = w;
      end
`ifdef BER_ALIGN_EARLY_LOCK_EN
      if (win_errs[w] == 0) begin
        nwin = w + 1;
        break;
      end
`endif
    end
    eoff = bw / DMAX;
    edly = bw % DMAX;
  endfunction

  task automatic test_reset();
    i_reset = 1'b0; i_enable = 1'b1; i_valid = 1'b0; i_error = 1'b0;
    repeat (3) tick();
    n_vec++; if (o_offset !== 2'd0) begin n_fail++; $display("FAIL rst_offset: got %0d expected 0", o_offset); end
    n_vec++; if (o_delay !== 9'd0) begin n_fail++; $display("FAIL rst_delay: got %0d expected 0", o_delay); end
    n_vec++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %0d expected 0", o_locked); end
    n_vec++; if (o_best_err !== 4'hf) begin n_fail++; $display("FAIL rst_best_err: got %0d expected 15", o_best_err); end
    n_vec++; if (o_bit_count !== 64'd0) begin n_fail++; $display("FAIL rst_bit_count: got %0d expected 0", o_bit_count); end
    n_vec++; if (o_error_count !== 64'd0) begin n_fail++; $display("FAIL rst_error_count: got %0d expected 0", o_error_count); end
    i_reset = 1'b1;
    tick();
    n_vec++; if (o_offset !== 2'd0 || o_delay !== 9'd0 || o_locked !== 1'b0) begin
      n_fail++; $display("FAIL rst_release: got off=%0d dly=%0d lk=%0d expected 0/0/0", o_offset, o_delay, o_locked); end
  endtask

  task automatic test_single_pair();
    int eoff, edly, eerr, nwin;
    for (int w = 0; w < NWIN; w++) win_errs[w] = (w == 2 * DMAX + 3) ? 0 : $urandom_range(WLEN, 1);
    predict(eoff, edly, eerr, nwin);
    drive_windows(nwin);
    for (int w = 0; w < nwin; w++) begin
      n_vec++; if (obs_off[w] !== w / DMAX || obs_dly[w] !== w % DMAX) begin
        n_fail++; $display("FAIL single_sweep_pair w%0d: got (%0d,%0d) expected (%0d,%0d)", w, obs_off[w], obs_dly[w], w / DMAX, w % DMAX); end
    end
    n_vec++; if (o_locked !== 1'b0 || int'(o_offset) !== eoff || int'(o_delay) !== edly) begin
      n_fail++; $display("FAIL single_lock_settle: got lk=%0d (%0d,%0d) expected 0 (%0d,%0d)", o_locked, o_offset, o_delay, eoff, edly); end
    repeat (SET) strobe(1'($urandom));
    n_vec++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL single_locked: got %0d expected 1", o_locked); end
    n_vec++; if (int'(o_offset) !== eoff || int'(o_delay) !== edly) begin
      n_fail++; $display("FAIL single_pair: got (%0d,%0d) expected (%0d,%0d)", o_offset, o_delay, eoff, edly); end
    n_vec++; if (int'(o_best_err) !== eerr) begin n_fail++; $display("FAIL single_best_err: got %0d expected %0d", o_best_err, eerr); end
    n_vec++; if (o_bit_count !== 64'd0) begin n_fail++; $display("FAIL single_bits_at_lock: got %0d expected 0", o_bit_count); end
    lock_off = eoff;
    lock_dly = edly;
  endtask

  task automatic test_lock_count();
    int r, k;
    logic e;
    r = 3;
    for (int s = 10; s > 0; s--) begin
      e = ($urandom_range(s - 1, 0) < r);
      if (e) r--;
      strobe(e);
    end
    n_vec++; if (o_bit_count !== 64'd10) begin n_fail++; $display("FAIL lock_bits: got %0d expected 10", o_bit_count); end
    n_vec++; if (o_error_count !== 64'd3) begin n_fail++; $display("FAIL lock_errors: got %0d expected 3", o_error_count); end
    k = 0;
    for (int s = 0; s < 10; s++) begin
      e = 1'($urandom);
      k += int'(e);
      strobe(e);
    end
    n_vec++; if (o_bit_count !== 64'd20) begin n_fail++; $display("FAIL lock_bits_20: got %0d expected 20", o_bit_count); end
    n_vec++; if (o_error_count !== 64'(3 + k)) begin n_fail++; $display("FAIL lock_errors_20: got %0d expected %0d", o_error_count, 3 + k); end
    n_vec++; if (s_bit_count !== 4'd15) begin n_fail++; $display("FAIL sat_bits: got %0d expected 15", s_bit_count); end
    n_vec++; if (int'(s_error_count) !== ((3 + k > 15) ? 15 : 3 + k)) begin
      n_fail++; $display("FAIL sat_errors: got %0d expected %0d", s_error_count, (3 + k > 15) ? 15 : 3 + k); end
  endtask

  task automatic test_enable_drop();
    i_enable = 1'b0;
    tick();
    n_vec++; if (o_locked !== 1'b0) begin n_fail++; $display("FAIL drop_lock_locked: got %0d expected 0", o_locked); end
    n_vec++; if (int'(o_offset) !== lock_off || int'(o_delay) !== lock_dly) begin
      n_fail++; $display("FAIL drop_lock_hold: got (%0d,%0d) expected (%0d,%0d)", o_offset, o_delay, lock_off, lock_dly); end
    repeat (2) strobe(1'b1);
    n_vec++; if (o_bit_count !== 64'd20) begin n_fail++; $display("FAIL drop_bits_hold: got %0d expected 20", o_bit_count); end
    i_enable = 1'b1;
    tick();
    n_vec++; if (o_offset !== 2'd0 || o_delay !== 9'd0 || o_bit_count !== 64'd0 || o_error_count !== 64'd0 || o_best_err !== 4'hf) begin
      n_fail++; $display("FAIL reenable_clear: got (%0d,%0d) bits=%0d errs=%0d best=%0d expected (0,0) 0 0 15",
                         o_offset, o_delay, o_bit_count, o_error_count, o_best_err); end
    for (int w = 0; w < NWIN; w++) win_errs[w] = $urandom_range(WLEN, 1);
    drive_windows(7);
    for (int w = 0; w < 7; w++) begin
      n_vec++; if (obs_off[w] !== w / DMAX || obs_dly[w] !== w % DMAX) begin
        n_fail++; $display("FAIL drop_sweep_pair w%0d: got (%0d,%0d) expected (%0d,%0d)", w, obs_off[w], obs_dly[w], w / DMAX, w % DMAX); end
    end
    repeat (SET + 3) strobe(1'($urandom));
    i_enable = 1'b0;
    tick();
    n_vec++; if (o_locked !== 1'b0 || o_offset !== 2'd1 || o_delay !== 9'd2) begin
      n_fail++; $display("FAIL drop_measure_hold: got lk=%0d (%0d,%0d) expected 0 (1,2)", o_locked, o_offset, o_delay); end
    repeat (3) tick();
    i_enable = 1'b1;
    tick();
    n_vec++; if (o_offset !== 2'd0 || o_delay !== 9'd0) begin
      n_fail++; $display("FAIL drop_restart: got (%0d,%0d) expected (0,0)", o_offset, o_delay); end
  endtask

  task automatic test_tie_break();
    int eoff, edly, eerr, nwin;
    for (int w = 0; w < NWIN; w++) win_errs[w] = (w == 1 * DMAX + 0 || w == 3 * DMAX + 4) ? 1 : $urandom_range(WLEN, 2);
    predict(eoff, edly, eerr, nwin);
    drive_windows(nwin);
    for (int w = 0; w < nwin; w++) begin
      n_vec++; if (obs_off[w] !== w / DMAX || obs_dly[w] !== w % DMAX) begin
        n_fail++; $display("FAIL tie_sweep_pair w%0d: got (%0d,%0d) expected (%0d,%0d)", w, obs_off[w], obs_dly[w], w / DMAX, w % DMAX); end
    end
    repeat (SET) strobe(1'($urandom));
    n_vec++; if (o_locked !== 1'b1) begin n_fail++; $display("FAIL tie_locked: got %0d expected 1", o_locked); end
    n_vec++; if (int'(o_offset) !== eoff || int'(o_delay) !== edly) begin
      n_fail++; $display("FAIL tie_pair: got (%0d,%0d) expected (%0d,%0d)", o_offset, o_delay, eoff, edly); end
    n_vec++; if (int'(o_best_err) !== eerr) begin n_fail++; $display("FAIL tie_best_err: got %0d expected %0d", o_best_err, eerr); end
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_lock_count();
    test_enable_drop();
    test_tie_break();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
